id_ex_forward_reg: RTL and testbench

ID_EX_FORWARD_REG -- requirements
Module: id_ex_forward_reg

---
 rtl/id_ex_forward_reg.sv | 133 +++++++++++++
 tb/tb_id_ex_forward_reg.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_forward_reg.sv
// ID/EX pipeline register with operand-forwarding selects and load-use hazard detection.
// Selects are computed from the ID specifiers and registered alongside the operands.
module id_ex_forward_reg #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic [REG_W-1:0]  id_rd,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic              flush,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [REG_W-1:0]  ex_rd,
   output logic              ex_valid,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic [1:0]        forward_a,
   output logic [1:0]        forward_b,
   output logic              stall
);

   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_WB  = 2'b01;
   localparam logic [1:0] SEL_MEM = 2'b10;

   logic [DATA_W-1:0] ex_rs_data_q, ex_rs_data_d;
   logic [DATA_W-1:0] ex_rt_data_q, ex_rt_data_d;
   logic [REG_W-1:0]  ex_rd_q, ex_rd_d;
   logic              ex_valid_q, ex_valid_d;
   logic              ex_reg_write_q, ex_reg_write_d;
   logic              ex_mem_read_q, ex_mem_read_d;
   logic [1:0]        forward_a_q, forward_a_d;
   logic [1:0]        forward_b_q, forward_b_d;
   logic [REG_W-1:0]  mem_rd_q, mem_rd_d;
   logic              mem_reg_write_q, mem_reg_write_d;

   logic ex_live;
   logic ex_fwd_ok;
   logic mem_live;
   logic stall_c;

   // A load in EX cannot forward yet; its consumers are stalled instead.
   function automatic logic [1:0] pick_src(input logic [REG_W-1:0] src,
                                           input logic [REG_W-1:0] ex_dst,
                                           input logic             ex_ok,
                                           input logic [REG_W-1:0] mem_dst,
                                           input logic             mem_ok);
      logic [1:0] sel;
      sel = SEL_RF;
      if (ex_ok && (src == ex_dst)) begin
         sel = SEL_MEM;
      end else if (mem_ok && (src == mem_dst)) begin
         sel = SEL_WB;
      end
      return sel;
   endfunction

   always_comb begin
      ex_live   = ex_valid_q & ex_reg_write_q & (ex_rd_q != '0);
      ex_fwd_ok = ex_live & ~ex_mem_read_q;
      mem_live  = mem_reg_write_q & (mem_rd_q != '0);
      stall_c   = id_valid & ex_valid_q & ex_mem_read_q & (ex_rd_q != '0) &
                  ((id_rs == ex_rd_q) | (id_rt == ex_rd_q));

      mem_rd_d        = ex_rd_q;
      mem_reg_write_d = ex_reg_write_q & ex_valid_q;

      ex_rs_data_d   = id_rs_data;
      ex_rt_data_d   = id_rt_data;
      ex_rd_d        = id_rd;
      ex_valid_d     = id_valid;
      ex_reg_write_d = id_reg_write & id_valid;
      ex_mem_read_d  = id_mem_read & id_valid;
      forward_a_d    = pick_src(id_rs, ex_rd_q, ex_fwd_ok, mem_rd_q, mem_live);
      forward_b_d    = pick_src(id_rt, ex_rd_q, ex_fwd_ok, mem_rd_q, mem_live);

      // Flush and stall both insert a fully zeroed bubble into EX.
      if (flush || stall_c) begin
         ex_rs_data_d   = '0;
         ex_rt_data_d   = '0;
         ex_rd_d        = '0;
         ex_valid_d     = 1'b0;
         ex_reg_write_d = 1'b0;
         ex_mem_read_d  = 1'b0;
         forward_a_d    = SEL_RF;
         forward_b_d    = SEL_RF;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_rs_data_q    <= '0;
         ex_rt_data_q    <= '0;
         ex_rd_q         <= '0;
         ex_valid_q      <= 1'b0;
         ex_reg_write_q  <= 1'b0;
         ex_mem_read_q   <= 1'b0;
         forward_a_q     <= SEL_RF;
         forward_b_q     <= SEL_RF;
         mem_rd_q        <= '0;
         mem_reg_write_q <= 1'b0;
      end else begin
         ex_rs_data_q    <= ex_rs_data_d;
         ex_rt_data_q    <= ex_rt_data_d;
         ex_rd_q         <= ex_rd_d;
         ex_valid_q      <= ex_valid_d;
         ex_reg_write_q  <= ex_reg_write_d;
         ex_mem_read_q   <= ex_mem_read_d;
         forward_a_q     <= forward_a_d;
         forward_b_q     <= forward_b_d;
         mem_rd_q        <= mem_rd_d;
         mem_reg_write_q <= mem_reg_write_d;
      end
   end

   assign ex_rs_data   = ex_rs_data_q;
   assign ex_rt_data   = ex_rt_data_q;
   assign ex_rd        = ex_rd_q;
   assign ex_valid     = ex_valid_q;
   assign ex_reg_write = ex_reg_write_q;
   assign ex_mem_read  = ex_mem_read_q;
   assign forward_a    = forward_a_q;
   assign forward_b    = forward_b_q;
   assign stall        = stall_c;

endmodule

// File: tb/tb_id_ex_forward_reg.sv
// Bench for id_ex_forward_reg: directed pipeline scenarios from a vector table,
// then random traffic checked against a stage-level reference model.
module tb_id_ex_forward_reg;

   logic        clk;
   logic        reset;
   logic        id_valid;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        id_reg_write, id_mem_read;
   logic [31:0] id_rs_data, id_rt_data;
   logic        flush;
   logic [31:0] ex_rs_data, ex_rt_data;
   logic [4:0]  ex_rd;
   logic        ex_valid, ex_reg_write, ex_mem_read;
   logic [1:0]  forward_a, forward_b;
   logic        stall;

   int n_cmp = 0;
   int n_err = 0;

   id_ex_forward_reg #(.DATA_W(32), .REG_W(5)) dut (
      .clk(clk), .reset(reset),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .flush(flush),
      .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_rd(ex_rd),
      .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .forward_a(forward_a), .forward_b(forward_b), .stall(stall)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst, vld;
      logic [4:0] rs, rt, rd;
      logic       rw, mr, fl;
      logic       e_stall;
      logic       e_vld, e_rw, e_mr;
      logic [4:0] e_rd;
      logic [1:0] e_fa, e_fb;
      logic       e_bub;
   } vec_t;

   function automatic vec_t mk(input logic rst, vld, input logic [4:0] rs, rt, rd,
                               input logic rw, mr, fl, e_stall, e_vld, e_rw, e_mr,
                               input logic [4:0] e_rd, input logic [1:0] e_fa, e_fb,
                               input logic e_bub);
      vec_t v;
      v.rst = rst; v.vld = vld; v.rs = rs; v.rt = rt; v.rd = rd;
      v.rw = rw; v.mr = mr; v.fl = fl; v.e_stall = e_stall;
      v.e_vld = e_vld; v.e_rw = e_rw; v.e_mr = e_mr; v.e_rd = e_rd;
      v.e_fa = e_fa; v.e_fb = e_fb; v.e_bub = e_bub;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // driver: inputs change just after the falling edge
   task automatic apply(input logic rst, vld, input logic [4:0] rs, rt, rd,
                        input logic rw, mr, fl, input logic [31:0] d0, d1);
      @(negedge clk);
      reset = rst; id_valid = vld; id_rs = rs; id_rt = rt; id_rd = rd;
      id_reg_write = rw; id_mem_read = mr; flush = fl;
      id_rs_data = d0; id_rt_data = d1;
      #1;
   endtask

   task automatic check_sel_legal(input string tag);
      check({tag, "_fa_not_11"}, {31'd0, forward_a == 2'b11}, 32'd0);
      check({tag, "_fb_not_11"}, {31'd0, forward_b == 2'b11}, 32'd0);
   endtask

   // reference model: one record per pipeline stage
   logic        m_ex_vld, m_ex_rw, m_ex_mr;
   logic [4:0]  m_ex_rd;
   logic [31:0] m_ex_d0, m_ex_d1;
   logic [1:0]  m_fa, m_fb;
   logic        m_mem_rw;
   logic [4:0]  m_mem_rd;

   function automatic logic [1:0] ref_src(input logic [4:0] r);
      if (r != 0 && m_ex_vld && m_ex_rw && !m_ex_mr && m_ex_rd == r) return 2'd2;
      if (r != 0 && m_mem_rw && m_mem_rd == r) return 2'd1;
      return 2'd0;
   endfunction

   vec_t vecs[17];

   initial begin
      logic exp_stall;
      logic [1:0] nfa, nfb;

      vecs[0]  = mk(1,0, 0,0,0, 0,0,0, 0, 0,0,0, 0, 0,0, 1);
      vecs[1]  = mk(0,1, 1,2,3, 1,0,0, 0, 1,1,0, 3, 0,0, 0); // add r3,r1,r2
      vecs[2]  = mk(0,1, 3,1,4, 1,0,0, 0, 1,1,0, 4, 2,0, 0); // add r4,r3,r1
      vecs[3]  = mk(0,1, 1,1,3, 1,0,0, 0, 1,1,0, 3, 0,0, 0); // add r3,r1,r1
      vecs[4]  = mk(0,0, 0,0,0, 0,0,0, 0, 0,0,0, 0, 0,0, 0); // nop
      vecs[5]  = mk(0,1, 2,3,5, 1,0,0, 0, 1,1,0, 5, 0,1, 0); // sub r5,r2,r3
      vecs[6]  = mk(0,1, 1,0,7, 1,1,0, 0, 1,1,1, 7, 0,0, 0); // lw r7
      vecs[7]  = mk(0,1, 7,7,8, 1,0,0, 1, 0,0,0, 0, 0,0, 1); // add r8,r7,r7 stalls
      vecs[8]  = mk(0,1, 7,7,8, 1,0,0, 0, 1,1,0, 8, 1,1, 0); // held, forwards from MEM
      vecs[9]  = mk(0,1, 1,1,0, 1,0,0, 0, 1,1,0, 0, 0,0, 0); // add r0
      vecs[10] = mk(0,1, 0,0,1, 1,0,0, 0, 1,1,0, 1, 0,0, 0); // add r1,r0,r0
      vecs[11] = mk(0,1, 2,0,7, 1,1,0, 0, 1,1,1, 7, 0,0, 0); // lw r7
      vecs[12] = mk(0,1, 7,1,8, 1,0,1, 1, 0,0,0, 0, 0,0, 1); // add r8,r7,r1 + flush
      vecs[13] = mk(0,1, 7,1,8, 1,0,0, 0, 1,1,0, 8, 1,0, 0);
      vecs[14] = mk(0,1, 1,0,7, 1,1,0, 0, 1,1,1, 7, 0,0, 0); // lw r7
      vecs[15] = mk(1,1, 7,7,8, 1,0,0, 1, 0,0,0, 0, 0,0, 1); // reset during stall
      vecs[16] = mk(0,1, 7,7,8, 1,0,0, 0, 1,1,0, 8, 0,0, 0); // load forgotten

      apply(1,0,0,0,0,0,0,0,0,0);
      @(posedge clk);
      apply(1,0,0,0,0,0,0,0,0,0);
      @(posedge clk);

      foreach (vecs[i]) begin
         vec_t v;
         logic [31:0] d0, d1;
         string t;
         v = vecs[i];
         d0 = 32'hA000_0000 + i;
         d1 = 32'hB000_0000 + i;
         t = $sformatf("vec%0d", i);
         apply(v.rst, v.vld, v.rs, v.rt, v.rd, v.rw, v.mr, v.fl, d0, d1);
         check({t, "_stall"}, {31'd0, stall}, {31'd0, v.e_stall});
         @(posedge clk);
         #1;
         check({t, "_ex_valid"}, {31'd0, ex_valid}, {31'd0, v.e_vld});
         check({t, "_ex_reg_write"}, {31'd0, ex_reg_write}, {31'd0, v.e_rw});
         check({t, "_ex_mem_read"}, {31'd0, ex_mem_read}, {31'd0, v.e_mr});
         check({t, "_ex_rd"}, {27'd0, ex_rd}, {27'd0, v.e_rd});
         check({t, "_forward_a"}, {30'd0, forward_a}, {30'd0, v.e_fa});
         check({t, "_forward_b"}, {30'd0, forward_b}, {30'd0, v.e_fb});
         check({t, "_ex_rs_data"}, ex_rs_data, v.e_bub ? 32'd0 : d0);
         check({t, "_ex_rt_data"}, ex_rt_data, v.e_bub ? 32'd0 : d1);
         check_sel_legal(t);
      end

      // random traffic, model and DUT both start from reset
      apply(1,0,0,0,0,0,0,0,0,0);
      @(posedge clk);
      m_ex_vld = 0; m_ex_rw = 0; m_ex_mr = 0; m_ex_rd = 0;
      m_ex_d0 = 0; m_ex_d1 = 0; m_fa = 0; m_fb = 0;
      m_mem_rw = 0; m_mem_rd = 0;

      for (int c = 0; c < 400; c++) begin
         logic rst, vld, rw, mr, fl;
         logic [4:0] rs, rt, rd;
         logic [31:0] d0, d1;
         rst = ($urandom_range(0, 39) == 0);
         vld = ($urandom_range(0, 3) != 0);
         rs  = 5'($urandom_range(0, 7));
         rt  = 5'($urandom_range(0, 7));
         rd  = 5'($urandom_range(0, 7));
         rw  = ($urandom_range(0, 3) != 0);
         mr  = ($urandom_range(0, 2) == 0);
         fl  = ($urandom_range(0, 9) == 0);
         d0  = $urandom;
         d1  = $urandom;
         apply(rst, vld, rs, rt, rd, rw, mr, fl, d0, d1);

         exp_stall = vld && m_ex_vld && m_ex_mr && m_ex_rd != 0 &&
                     (rs == m_ex_rd || rt == m_ex_rd);
         check("rnd_stall", {31'd0, stall}, {31'd0, exp_stall});

         nfa = ref_src(rs);
         nfb = ref_src(rt);
         if (rst) begin
            m_mem_rw = 0; m_mem_rd = 0;
         end else begin
            m_mem_rw = m_ex_rw && m_ex_vld;
            m_mem_rd = m_ex_rd;
         end
         if (rst || fl || exp_stall) begin
            m_ex_vld = 0; m_ex_rw = 0; m_ex_mr = 0; m_ex_rd = 0;
            m_ex_d0 = 0; m_ex_d1 = 0; m_fa = 0; m_fb = 0;
         end else begin
            m_ex_vld = vld; m_ex_rw = rw && vld; m_ex_mr = mr && vld; m_ex_rd = rd;
            m_ex_d0 = d0; m_ex_d1 = d1; m_fa = nfa; m_fb = nfb;
         end

         @(posedge clk);
         #1;
         check("rnd_ex_valid", {31'd0, ex_valid}, {31'd0, m_ex_vld});
         check("rnd_ex_reg_write", {31'd0, ex_reg_write}, {31'd0, m_ex_rw});
         check("rnd_ex_mem_read", {31'd0, ex_mem_read}, {31'd0, m_ex_mr});
         check("rnd_ex_rd", {27'd0, ex_rd}, {27'd0, m_ex_rd});
         check("rnd_ex_rs_data", ex_rs_data, m_ex_d0);
         check("rnd_ex_rt_data", ex_rt_data, m_ex_d1);
         check("rnd_forward_a", {30'd0, forward_a}, {30'd0, m_fa});
         check("rnd_forward_b", {30'd0, forward_b}, {30'd0, m_fb});
         check_sel_legal("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
